// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
// The PISO_TX_PARITY_EN macro selects whether each frame carries a trailing even-parity step.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

`ifdef PISO_TX_PARITY_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  // The counter must hold WIDTH+1 when parity is enabled, so size it for WIDTH+2 values.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic int frame_len(input int width);
    return width + FRAME_EXTRA;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle between a word producer and piso_tx.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] PD;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             SHIFT_EN;
  logic             SO;
  logic             SO_VALID;
  logic             LAST;
  logic             BUSY;

  modport master (
    output PD, LOAD_VALID, SHIFT_EN,
    input  LOAD_READY, SO, SO_VALID, LAST, BUSY
  );

  modport slave (
    input  PD, LOAD_VALID, SHIFT_EN,
    output LOAD_READY, SO, SO_VALID, LAST, BUSY
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: MSB first, inverted line, one-word hold buffer.
// Optional PISO_TX_PARITY_EN appends an even-parity step to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic      CK,
  input  logic      nRESET,
  piso_tx_if.slave  bus
);

  localparam int                FRAME    = frame_len(WIDTH);
  localparam int                CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]     CNT_LOAD = CW'(FRAME);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

  state_t           state;
  logic [FRAME-1:0] sreg;
  logic [FRAME-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;

  logic accept;
  logic final_step;

  // Parity is computed once at load time so the hold entry is already a complete frame.
  function automatic logic [FRAME-1:0] frame_word(input logic [WIDTH-1:0] pd);
`ifdef PISO_TX_PARITY_EN
    return {pd, ^pd};
`else
    return pd;
`endif
  endfunction

  assign accept     = bus.LOAD_VALID & ~hold_full;
  assign final_step = (state == SHIFT) & bus.SHIFT_EN & (cnt == CNT_ONE);

  always_ff @(negedge CK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= frame_word(bus.PD);
            cnt   <= CNT_LOAD;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (final_step) begin
            // A held word wins over a bypass load; hold_full already blocks accept here.
            if (hold_full) begin
              sreg      <= hold;
              hold_full <= 1'b0;
              cnt       <= CNT_LOAD;
            end else if (accept) begin
              sreg <= frame_word(bus.PD);
              cnt  <= CNT_LOAD;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            if (bus.SHIFT_EN) begin
              sreg <= sreg << 1;
              cnt  <= cnt - 1'b1;
            end
            if (accept) hold_full <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(negedge CK) begin
    if ((state == SHIFT) && !final_step && accept) hold <= frame_word(bus.PD);
  end

  assign bus.LOAD_READY = ~hold_full;
  assign bus.SO_VALID   = (state == SHIFT);
  assign bus.SO         = (state == SHIFT) ? ~sreg[FRAME-1] : 1'b1;
  assign bus.LAST       = (state == SHIFT) & (cnt == CNT_ONE);
  assign bus.BUSY       = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx (WIDTH=4) with an FS1-style falling-edge receiver model.
module tb_piso_tx;
  import piso_pkg::*;

  logic CK;
  logic nRESET;
  int   total;
  int   passed;
  logic [3:0] rq;

  piso_tx_if #(.WIDTH(4)) bus ();

  piso_tx #(.WIDTH(4)) dut (
    .CK     (CK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Reference receiver: inverts the line and shifts MSB first on qualified falling edges.
  always @(negedge CK) begin
    if (bus.SHIFT_EN) rq <= {rq[2:0], ~bus.SO};
  end

  task automatic test_reset();
    nRESET = 1'b0;
    bus.PD = 4'h0;
    bus.LOAD_VALID = 1'b0;
    bus.SHIFT_EN = 1'b0;
    #3;
    total++; if (bus.SO !== 1'b1) $display("FAIL reset_so: got %b expected 1", bus.SO); else passed++;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL reset_so_valid: got %b expected 0", bus.SO_VALID); else passed++;
    total++; if (bus.LAST !== 1'b0) $display("FAIL reset_last: got %b expected 0", bus.LAST); else passed++;
    total++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.BUSY); else passed++;
    total++; if (bus.LOAD_READY !== 1'b1) $display("FAIL reset_load_ready: got %b expected 1", bus.LOAD_READY); else passed++;
    @(posedge CK); #1;
    nRESET = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] word;
    word = 4'hA;
    @(posedge CK); #1;
    bus.PD = word; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b1;
    total++; if (bus.LOAD_READY !== 1'b1) $display("FAIL single_ready: got %b expected 1", bus.LOAD_READY); else passed++;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.SO !== ~word[3-i]) $display("FAIL single_so[%0d]: got %b expected %b", i, bus.SO, ~word[3-i]); else passed++;
      total++; if (bus.SO_VALID !== 1'b1) $display("FAIL single_valid[%0d]: got %b expected 1", i, bus.SO_VALID); else passed++;
      total++; if (bus.LAST !== (i == 3)) $display("FAIL single_last[%0d]: got %b expected %b", i, bus.LAST, (i == 3)); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (bus.SO !== 1'b1) $display("FAIL single_idle_so: got %b expected 1", bus.SO); else passed++;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL single_idle_valid: got %b expected 0", bus.SO_VALID); else passed++;
    total++; if (rq !== 4'hA) $display("FAIL single_rx: got %h expected a", rq); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'h3C;
    @(posedge CK); #1;
    bus.PD = 4'h3; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b1;
    @(posedge CK); #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        bus.PD = 4'hC; bus.LOAD_VALID = 1'b1;
      end else if (i == 1) begin
        bus.LOAD_VALID = 1'b0;
        total++; if (bus.LOAD_READY !== 1'b0) $display("FAIL b2b_ready_low: got %b expected 0", bus.LOAD_READY); else passed++;
        total++; if (bus.BUSY !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", bus.BUSY); else passed++;
      end else if (i == 4) begin
        total++; if (rq !== 4'h3) $display("FAIL b2b_rx_first: got %h expected 3", rq); else passed++;
        total++; if (bus.LOAD_READY !== 1'b1) $display("FAIL b2b_ready_back: got %b expected 1", bus.LOAD_READY); else passed++;
      end
      total++; if (bus.SO_VALID !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.SO_VALID); else passed++;
      total++; if (bus.SO !== ~seq[7-i]) $display("FAIL b2b_so[%0d]: got %b expected %b", i, bus.SO, ~seq[7-i]); else passed++;
      total++; if (bus.LAST !== (i == 3 || i == 7)) $display("FAIL b2b_last[%0d]: got %b expected %b", i, bus.LAST, (i == 3 || i == 7)); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (rq !== 4'hC) $display("FAIL b2b_rx_second: got %h expected c", rq); else passed++;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", bus.SO_VALID); else passed++;
  endtask

  task automatic test_stall();
    logic [5:0] se_pat;
    logic [5:0] exp_so;
    se_pat = 6'b100111;
    exp_so = 6'b100010;
    @(posedge CK); #1;
    bus.PD = 4'h5; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b0;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.SHIFT_EN = se_pat[5-i];
      total++; if (bus.SO !== exp_so[5-i]) $display("FAIL stall_so[%0d]: got %b expected %b", i, bus.SO, exp_so[5-i]); else passed++;
      total++; if (bus.LAST !== (i == 5)) $display("FAIL stall_last[%0d]: got %b expected %b", i, bus.LAST, (i == 5)); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL stall_idle: got %b expected 0", bus.SO_VALID); else passed++;
    total++; if (rq !== 4'h5) $display("FAIL stall_rx: got %h expected 5", rq); else passed++;
  endtask

  task automatic test_bypass();
    logic [7:0] seq;
    seq = 8'h69;
    @(posedge CK); #1;
    bus.PD = 4'h6; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b1;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus.PD = 4'h9; bus.LOAD_VALID = 1'b1;
      end else if (i == 4) begin
        bus.LOAD_VALID = 1'b0;
        total++; if (rq !== 4'h6) $display("FAIL bypass_rx_first: got %h expected 6", rq); else passed++;
      end
      total++; if (bus.LOAD_READY !== 1'b1) $display("FAIL bypass_ready[%0d]: got %b expected 1", i, bus.LOAD_READY); else passed++;
      total++; if (bus.SO_VALID !== 1'b1) $display("FAIL bypass_valid[%0d]: got %b expected 1", i, bus.SO_VALID); else passed++;
      total++; if (bus.SO !== ~seq[7-i]) $display("FAIL bypass_so[%0d]: got %b expected %b", i, bus.SO, ~seq[7-i]); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (rq !== 4'h9) $display("FAIL bypass_rx_second: got %h expected 9", rq); else passed++;
    total++; if (bus.BUSY !== 1'b0) $display("FAIL bypass_idle_busy: got %b expected 0", bus.BUSY); else passed++;
  endtask

  task automatic test_async_reset();
    @(posedge CK); #1;
    bus.PD = 4'hF; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b1;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    @(posedge CK); #1;
    @(posedge CK); #1;
    total++; if (bus.SO_VALID !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", bus.SO_VALID); else passed++;
    nRESET = 1'b0;
    #1;
    total++; if (bus.SO !== 1'b1) $display("FAIL areset_so: got %b expected 1", bus.SO); else passed++;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL areset_valid: got %b expected 0", bus.SO_VALID); else passed++;
    total++; if (bus.BUSY !== 1'b0) $display("FAIL areset_busy: got %b expected 0", bus.BUSY); else passed++;
    total++; if (bus.LOAD_READY !== 1'b1) $display("FAIL areset_ready: got %b expected 1", bus.LOAD_READY); else passed++;
    @(posedge CK); #1;
    nRESET = 1'b1;
    bus.PD = 4'h1; bus.LOAD_VALID = 1'b1;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.SO !== (i != 3)) $display("FAIL areset_so_after[%0d]: got %b expected %b", i, bus.SO, (i != 3)); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (rq !== 4'h1) $display("FAIL areset_rx: got %h expected 1", rq); else passed++;
  endtask

  task automatic test_parity();
    logic [4:0] exp_so;
    exp_so = 5'b10000;
    @(posedge CK); #1;
    bus.PD = 4'h7; bus.LOAD_VALID = 1'b1; bus.SHIFT_EN = 1'b1;
    @(posedge CK); #1;
    bus.LOAD_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.SO !== exp_so[4-i]) $display("FAIL parity_so[%0d]: got %b expected %b", i, bus.SO, exp_so[4-i]); else passed++;
      total++; if (bus.LAST !== (i == 4)) $display("FAIL parity_last[%0d]: got %b expected %b", i, bus.LAST, (i == 4)); else passed++;
      @(posedge CK); #1;
    end
    bus.SHIFT_EN = 1'b0;
    total++; if (bus.SO_VALID !== 1'b0) $display("FAIL parity_idle: got %b expected 0", bus.SO_VALID); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`else
    test_single();
    test_back_to_back();
    test_stall();
    test_bypass();
    test_async_reset();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
